sram_controller: RTL and testbench

Sequencing controller for one 32-bit asynchronous SRAM bank (BaseRAM or ExtRAM); two instances sit between the system bus and the board SRAM pins. Each instance accepts a load or store held by the bus, runs a fixed-length SRAM read or write cycle on registered pin outputs, and reports completion by dropping `busy`. Read data is valid in the same cycle `busy` falls.

---
 rtl/sram_controller.sv | 145 ++++++++++++++
 tb/tb_sram_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Purpose  : Sequences fixed-length read/write cycles on one 32-bit async SRAM
//            bank with registered pin outputs; completion is signalled by busy.
// Revision : 1.0 - initial release
// ============================================================================

module sram_controller #(
    parameter int READ_CYCLES = 2,
    parameter int WE_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [19:0] ram_addr,
    output logic [31:0] ram_data_o,
    output logic        ram_data_oe,
    input  logic [31:0] ram_data_i,
    output logic [3:0]  ram_be_n,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [3:0] C_READ_LOAD = 4'(READ_CYCLES - 1);
    localparam logic [3:0] C_WE_LOAD   = 4'(WE_CYCLES - 1);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;
    logic       w_req;
    logic       w_latch;
    logic       w_read_done;
    logic       w_next_read;
    logic       w_next_write;
    logic       w_next_pulse;
    logic       w_unused_addr;

    assign w_req         = load | store;
    assign busy          = w_req && (r_state != S_DONE);
    assign w_latch       = (r_state == S_IDLE) && w_req;
    assign w_read_done   = (r_state == S_READ) && (r_cnt == 4'd0);
    assign w_unused_addr = ^{addr[31:22], addr[1:0]};

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_next_state = S_READ;
                    w_next_cnt   = C_READ_LOAD;
                end else if (store) begin
                    w_next_state = S_WR_SETUP;
                end
            end
            S_READ: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            S_WR_SETUP: begin
                w_next_cnt   = C_WE_LOAD;
                w_next_state = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_WR_HOLD;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            S_WR_HOLD: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                // A request still held after completion must not re-run
                if (!w_req) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Pins are decoded from the next state so each edge lands on state entry
    assign w_next_read  = (w_next_state == S_READ);
    assign w_next_pulse = (w_next_state == S_WR_PULSE);
    assign w_next_write = (w_next_state == S_WR_SETUP) || w_next_pulse ||
                          (w_next_state == S_WR_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            rdata       <= 32'h0;
            ram_addr    <= 20'h0;
            ram_data_o  <= 32'h0;
            ram_data_oe <= 1'b0;
            ram_be_n    <= 4'hF;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            ram_ce_n    <= !(w_next_read || w_next_write);
            ram_oe_n    <= !w_next_read;
            ram_we_n    <= !w_next_pulse;
            ram_data_oe <= w_next_write;
            if (w_latch) begin
                ram_addr <= addr[21:2];
                ram_be_n <= ~byte_en;
                if (!load) begin
                    ram_data_o <= wdata;
                end
            end
            if (w_read_done) begin
                rdata <= ram_data_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_controller
// Purpose  : Directed + random checks of two sram_controller instances
//            (default timing and READ_CYCLES=4/WE_CYCLES=3) against SRAM models.
// Revision : 1.0 - initial release
// ============================================================================

module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        mem_clr;
    logic        load        [2];
    logic        store       [2];
    logic [31:0] addr        [2];
    logic [31:0] wdata       [2];
    logic [3:0]  byte_en     [2];
    logic [31:0] rdata       [2];
    logic        busy        [2];
    logic [19:0] ram_addr    [2];
    logic [31:0] ram_data_o  [2];
    logic        ram_data_oe [2];
    logic [31:0] ram_data_i  [2];
    logic [3:0]  ram_be_n    [2];
    logic        ram_ce_n    [2];
    logic        ram_oe_n    [2];
    logic        ram_we_n    [2];
    logic        pre_we      [2];
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;

    logic [31:0] exp_mem [2][1024];
    logic [31:0] last_rd [2];
    int          checks;
    int          errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [31:0] mem [1024];

        sram_controller #(
            .READ_CYCLES((g == 0) ? 2 : 4),
            .WE_CYCLES  ((g == 0) ? 1 : 3)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .load       (load[g]),
            .store      (store[g]),
            .addr       (addr[g]),
            .wdata      (wdata[g]),
            .byte_en    (byte_en[g]),
            .rdata      (rdata[g]),
            .busy       (busy[g]),
            .ram_addr   (ram_addr[g]),
            .ram_data_o (ram_data_o[g]),
            .ram_data_oe(ram_data_oe[g]),
            .ram_data_i (ram_data_i[g]),
            .ram_be_n   (ram_be_n[g]),
            .ram_ce_n   (ram_ce_n[g]),
            .ram_oe_n   (ram_oe_n[g]),
            .ram_we_n   (ram_we_n[g])
        );

        assign ram_data_i[g] = (!ram_ce_n[g] && !ram_oe_n[g]) ? mem[ram_addr[g][9:0]] : 32'h0;

        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            end else if (pre_we[g]) begin
                mem[pre_addr] <= pre_data;
            end else if (!ram_ce_n[g] && !ram_we_n[g] && ram_data_oe[g]) begin
                for (int b = 0; b < 4; b++)
                    if (!ram_be_n[g][b]) mem[ram_addr[g][9:0]][8*b +: 8] <= ram_data_o[g][8*b +: 8];
            end
        end
    end

    function automatic int rc(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int wc(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; strobe relationships must hold in every cycle on both banks
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("oe_we_overlap", {31'b0, !ram_oe_n[d] && !ram_we_n[d]}, 32'h0);
            check("drive_while_oe", {31'b0, ram_data_oe[d] && !ram_oe_n[d]}, 32'h0);
        end
    endtask

    task automatic op(input int d, input bit ld, input bit st, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input int hold,
                      input string tag);
        int cyc;
        int n_oe;
        int n_we;
        int n_doe;
        bit is_read;
        is_read = ld;
        load[d] = ld; store[d] = st; addr[d] = a; wdata[d] = wd; byte_en[d] = be;
        #1;
        check({tag, "_busy0"}, {31'b0, busy[d]}, 32'h1);
        cyc = 0; n_oe = 0; n_we = 0; n_doe = 0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (!ram_oe_n[d]) n_oe++;
            if (!ram_we_n[d]) n_we++;
            if (ram_data_oe[d]) n_doe++;
            if (cyc == 1) begin
                check({tag, "_addr"}, {12'b0, ram_addr[d]}, {12'b0, a[21:2]});
                check({tag, "_be_n"}, {28'b0, ram_be_n[d]}, {28'b0, ~be});
                if (!is_read) check({tag, "_wdata"}, ram_data_o[d], wd);
            end
            if (!busy[d]) break;
        end
        check({tag, "_latency"}, cyc, is_read ? rc(d) + 1 : wc(d) + 3);
        check({tag, "_oe_cycles"}, n_oe, is_read ? rc(d) : 0);
        check({tag, "_we_cycles"}, n_we, is_read ? 0 : wc(d));
        check({tag, "_drive_cycles"}, n_doe, is_read ? 0 : wc(d) + 2);
        if (is_read) last_rd[d] = exp_mem[d][a[11:2]];
        else exp_mem[d][a[11:2]] = merge(exp_mem[d][a[11:2]], wd, be);
        check({tag, "_rdata"}, rdata[d], last_rd[d]);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_held_busy"}, {31'b0, busy[d]}, 32'h0);
            check({tag, "_held_idle_pins"}, {29'b0, ram_ce_n[d], ram_oe_n[d], ram_we_n[d]}, 32'h7);
            check({tag, "_held_rdata"}, rdata[d], last_rd[d]);
        end
        load[d] = 1'b0; store[d] = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; mem_clr = 1'b1; pre_addr = 10'h0; pre_data = 32'h0;
        for (int d = 0; d < 2; d++) begin
            load[d] = (d == 0); store[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
            byte_en[d] = 4'h0; pre_we[d] = 1'b0; last_rd[d] = 32'h0;
            for (int i = 0; i < 1024; i++) exp_mem[d][i] = 32'h0;
            exp_mem[d][16] = 32'hDEADBEEF;
        end
        tick();
        tick();
        check("rst_busy_req", {31'b0, busy[0]}, 32'h1);
        check("rst_busy_noreq", {31'b0, busy[1]}, 32'h0);
        for (int d = 0; d < 2; d++) begin
            check("rst_rdata", rdata[d], 32'h0);
            check("rst_ram_addr", {12'b0, ram_addr[d]}, 32'h0);
            check("rst_data_o", ram_data_o[d], 32'h0);
            check("rst_data_oe", {31'b0, ram_data_oe[d]}, 32'h0);
            check("rst_be_n", {28'b0, ram_be_n[d]}, 32'hF);
            check("rst_strobes", {29'b0, ram_ce_n[d], ram_oe_n[d], ram_we_n[d]}, 32'h7);
        end
        load[0] = 1'b0; mem_clr = 1'b0;
        pre_we[0] = 1'b1; pre_we[1] = 1'b1; pre_addr = 10'h010; pre_data = 32'hDEADBEEF;
        tick();
        pre_we[0] = 1'b0; pre_we[1] = 1'b0; rst = 1'b0;
        tick();

        // Default-timing read, byte write and readback
        op(0, 1, 0, 32'h8000_0040, 32'h0, 4'hF, 0, "rd_default");
        check("rd_default_value", rdata[0], 32'hDEADBEEF);
        op(0, 0, 1, 32'h8000_0004, 32'h1122_3344, 4'b0010, 0, "byte_wr");
        op(0, 1, 0, 32'h8000_0004, 32'h0, 4'hF, 0, "byte_rd");
        check("byte_word1", rdata[0], 32'h0000_3300);

        // Slow instance
        op(1, 1, 0, 32'h0000_0040, 32'h0, 4'hF, 0, "rd_slow");
        check("rd_slow_value", rdata[1], 32'hDEADBEEF);
        op(1, 0, 1, 32'h0000_0008, 32'hA5A5_5A5A, 4'b1001, 0, "wr_slow");
        op(1, 1, 0, 32'h0000_0008, 32'h0, 4'hF, 0, "rd_slow2");

        // Request held well past completion, then an immediate follow-on
        op(0, 1, 0, 32'h0000_0040, 32'h0, 4'hF, 5, "held");
        op(0, 1, 0, 32'h0000_0004, 32'h0, 4'hF, 0, "after_held");

        // Reset in the middle of the slow write pulse
        store[1] = 1'b1; addr[1] = 32'h0000_0014; wdata[1] = 32'h1357_9BDF; byte_en[1] = 4'hF;
        tick();
        tick();
        tick();
        rst = 1'b1; store[1] = 1'b0;
        tick();
        check("midrst_strobes", {29'b0, ram_ce_n[1], ram_oe_n[1], ram_we_n[1]}, 32'h7);
        check("midrst_data_oe", {31'b0, ram_data_oe[1]}, 32'h0);
        check("midrst_rdata0", rdata[0], 32'h0);
        check("midrst_rdata1", rdata[1], 32'h0);
        check("midrst_busy", {31'b0, busy[1]}, 32'h0);
        rst = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        // The pulse was already on the pins before reset, so the word landed
        exp_mem[1][5] = 32'h1357_9BDF;
        op(1, 1, 0, 32'h0000_0040, 32'h0, 4'hF, 0, "postrst_rd");
        op(1, 1, 0, 32'h0000_0014, 32'h0, 4'hF, 0, "postrst_rd2");

        // Simultaneous requests: read wins, memory untouched
        op(0, 1, 1, 32'h8000_0040, 32'hCAFE_F00D, 4'hF, 0, "both");
        op(0, 1, 0, 32'h8000_0040, 32'h0, 4'hF, 0, "both_rb");
        check("both_unchanged", rdata[0], 32'hDEADBEEF);

        for (int i = 0; i < 60; i++) begin
            int d;
            int kind;
            logic [31:0] a;
            d = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            a = ($urandom & 32'hFFC0_0003) | (32'($urandom_range(0, 15)) << 2);
            op(d, kind <= 4, kind == 0 || kind >= 5, a, $urandom, 4'($urandom),
               int'($urandom_range(0, 2)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
